// File: rtl/bist_pkg.sv
// bist_pkg: shared types and step functions for the pattern generator / MISR BIST.
// FSM state encoding, Fibonacci LFSR tap table (widths 3..16), and single-step
// LFSR and MISR functions operating on fixed maximum-width vectors.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned LFSR_MAX_W = 16;
  localparam int unsigned MISR_MAX_W = 32;

  // Maximal-length XOR tap masks, bit (n-1) set for tap n.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_taps(input int unsigned width);
    logic [LFSR_MAX_W-1:0] taps;
    case (width)
      3:       taps = 16'h0006;
      4:       taps = 16'h000C;
      5:       taps = 16'h0014;
      6:       taps = 16'h0030;
      7:       taps = 16'h0060;
      8:       taps = 16'h00B8;
      9:       taps = 16'h0110;
      10:      taps = 16'h0240;
      11:      taps = 16'h0500;
      12:      taps = 16'h0829;
      13:      taps = 16'h100D;
      14:      taps = 16'h2015;
      15:      taps = 16'h6000;
      16:      taps = 16'hD008;
      default: taps = '0;
    endcase
    return taps;
  endfunction

  // One Fibonacci step: shift left, feedback parity of tapped bits into bit 0.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_step(input logic [LFSR_MAX_W-1:0] val,
                                                      input int unsigned width);
    logic [LFSR_MAX_W-1:0] mask;
    logic                  fb;
    mask = LFSR_MAX_W'((32'd1 << width) - 32'd1);
    fb   = ^(val & lfsr_taps(width));
    return {val[LFSR_MAX_W-2:0], fb} & mask;
  endfunction

  // One MISR step: shift left, fold polynomial when the MSB falls out, xor response.
  function automatic logic [MISR_MAX_W-1:0] misr_step(input logic [MISR_MAX_W-1:0] sig,
                                                      input logic [MISR_MAX_W-1:0] rsp,
                                                      input logic [MISR_MAX_W-1:0] poly,
                                                      input int unsigned width);
    logic [MISR_MAX_W-1:0] mask;
    logic                  msb;
    mask = (32'd1 << width) - 32'd1;
    msb  = |(sig & (32'd1 << (width - 1)));
    return ((sig << 1) ^ (msb ? poly : '0) ^ rsp) & mask;
  endfunction

endpackage

// File: rtl/misr_reg.sv
// misr_reg: multiple-input signature register with synchronous clear and enable.
// Optional BIST_GOLDEN_CMP_EN exposes the next-state signature for a golden compare.
// SIG_W up to 32.
module misr_reg
  import bist_pkg::*;
#(
  parameter int unsigned            SIG_W     = 16,
  parameter int unsigned            RSP_W     = 3,
  parameter logic [MISR_MAX_W-1:0]  MISR_POLY = 32'h0000_1021,
  parameter logic [MISR_MAX_W-1:0]  SIG_SEED  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [RSP_W-1:0] rsp,
  output logic [SIG_W-1:0] sig
`ifdef BIST_GOLDEN_CMP_EN
  , output logic [SIG_W-1:0] sig_next
`endif
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;
  logic [SIG_W-1:0] sig_step;

  // Next signature: clear to seed, compact one response, or hold.
  always_comb begin
    sig_step = SIG_W'(misr_step(MISR_MAX_W'(sig_q), MISR_MAX_W'(rsp), MISR_POLY, SIG_W));
    sig_d    = sig_q;
    if (clr) begin
      sig_d = SIG_W'(SIG_SEED);
    end else if (en) begin
      sig_d = sig_step;
    end
  end

  // Signature register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= SIG_W'(SIG_SEED);
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;
`ifdef BIST_GOLDEN_CMP_EN
  assign sig_next = sig_step;
`endif

endmodule

// File: rtl/pattern_gen_misr.sv
// pattern_gen_misr: BIST driver. Generates VEC_W-bit stimulus (counter or LFSR),
// applies one vector per cycle and compacts the combinational DUT response into a MISR.
// Optional BIST_GOLDEN_CMP_EN adds golden_sig/pass signature comparison.
module pattern_gen_misr
  import bist_pkg::*;
#(
  parameter int unsigned           VEC_W        = 5,
  parameter int unsigned           RSP_W        = 3,
  parameter int unsigned           SIG_W        = 16,
  parameter int unsigned           NUM_PATTERNS = 32,
  parameter int unsigned           GEN_MODE     = 0,
  parameter logic [LFSR_MAX_W-1:0] LFSR_SEED    = 16'd1,
  parameter logic [MISR_MAX_W-1:0] MISR_POLY    = 32'h0000_1021,
  parameter logic [MISR_MAX_W-1:0] SIG_SEED     = '0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic                                abort,
  output logic [VEC_W-1:0]                    stim,
  output logic                                stim_valid,
  input  logic [RSP_W-1:0]                    rsp,
  output logic                                busy,
  output logic                                done,
  output logic [$clog2(NUM_PATTERNS+1)-1:0]   vec_cnt,
  output logic [SIG_W-1:0]                    signature
`ifdef BIST_GOLDEN_CMP_EN
  , input  logic [SIG_W-1:0]                  golden_sig
  , output logic                              pass
`endif
);

  localparam int unsigned      CNT_W      = $clog2(NUM_PATTERNS + 1);
  localparam logic [VEC_W-1:0] SEED_TRUNC = VEC_W'(LFSR_SEED);
  // A zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [VEC_W-1:0] FIRST_VEC  = (GEN_MODE == 0) ? '0 :
                                            ((SEED_TRUNC == '0) ? VEC_W'(1) : SEED_TRUNC);
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(NUM_PATTERNS - 1);

  state_e           state_q, state_d;
  logic [VEC_W-1:0] stim_q, stim_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [VEC_W-1:0] next_vec;
  logic             load;
  logic             step;
  logic             last;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      stim_q    <= '0;
      vec_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      stim_q    <= stim_d;
      vec_cnt_q <= vec_cnt_d;
    end
  end

  // Next-state logic; abort wins over start and over the final-vector exit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!abort && start) state_d = RUN;
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (vec_cnt_q == LAST_CNT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (start) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    busy       = (state_q == RUN);
    stim_valid = (state_q == RUN);
    done       = (state_q == DONE);
  end

  // Generator and counter: load on (re)start, advance each RUN cycle, hold stim on the last one.
  always_comb begin
    if (GEN_MODE == 0) begin
      next_vec = stim_q + VEC_W'(1);
    end else begin
      next_vec = VEC_W'(lfsr_step(LFSR_MAX_W'(stim_q), VEC_W));
    end
    load      = (state_q != RUN) && start && !abort;
    step      = (state_q == RUN) && !abort;
    last      = step && (vec_cnt_q == LAST_CNT);
    stim_d    = stim_q;
    vec_cnt_d = vec_cnt_q;
    if (load) begin
      stim_d    = FIRST_VEC;
      vec_cnt_d = '0;
    end else if (step) begin
      vec_cnt_d = vec_cnt_q + CNT_W'(1);
      if (!last) stim_d = next_vec;
    end
  end

  assign stim    = stim_q;
  assign vec_cnt = vec_cnt_q;

`ifdef BIST_GOLDEN_CMP_EN
  logic [SIG_W-1:0] sig_next;
  logic             pass_q, pass_d;

  // Golden compare against the signature being written on the DONE-entry edge.
  always_comb begin
    pass_d = pass_q;
    if (load || abort) begin
      pass_d = 1'b0;
    end else if (last) begin
      pass_d = (sig_next == golden_sig);
    end
  end

  // Pass flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_q <= 1'b0;
    end else begin
      pass_q <= pass_d;
    end
  end

  assign pass = pass_q;
`endif

  misr_reg #(
    .SIG_W     (SIG_W),
    .RSP_W     (RSP_W),
    .MISR_POLY (MISR_POLY),
    .SIG_SEED  (SIG_SEED)
  ) u_misr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (load),
    .en       (step),
    .rsp      (rsp),
    .sig      (signature)
`ifdef BIST_GOLDEN_CMP_EN
    , .sig_next (sig_next)
`endif
  );

endmodule
